// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, unsigned or signed (truncating), with a fixed
// 10-cycle latency per operation including the divide-by-zero case.
module seq_divider #(
  parameter int N_BIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             op_sel_in,
  input  logic [N_BIT-1:0] dividend_in,
  input  logic [N_BIT-1:0] divisor_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [N_BIT-1:0] quot_out,
  output logic [N_BIT-1:0] rem_out,
  output logic             dbz_out
);

  localparam int CNT_W = $clog2(N_BIT);
  localparam logic [N_BIT-1:0] ONE     = N_BIT'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(N_BIT - 1);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt;
  logic [N_BIT:0]   r;
  logic [N_BIT-1:0] q, d, dvd_raw;
  logic             sign_q, sign_r;
  logic             sd, sv;
  logic [N_BIT+1:0] r_sh;
  logic signed [N_BIT+1:0] t;
  logic             t_nonneg;

  function automatic logic [N_BIT-1:0] apply_sign(input logic [N_BIT-1:0] v,
                                                   input logic neg);
    return neg ? (~v + ONE) : v;
  endfunction

  // |-2^(N-1)| wraps to 2^(N-1), which is still the correct unsigned magnitude.
  function automatic logic [N_BIT-1:0] magnitude(input logic [N_BIT-1:0] v,
                                                  input logic is_signed);
    return apply_sign(v, is_signed & v[N_BIT-1]);
  endfunction

  assign sd = op_sel_in & dividend_in[N_BIT-1];
  assign sv = op_sel_in & divisor_in[N_BIT-1];

  // R < D always holds between iterations, so the shifted value stays below
  // 2^(N+1) and the sign of t is a true borrow indication.
  assign r_sh     = {r, q[N_BIT-1]};
  assign t        = $signed(r_sh) - $signed({2'b00, d});
  assign t_nonneg = ~t[N_BIT+1];

  assign busy_out = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_in) state_nxt = DIV;
      DIV:     if (cnt == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      r        <= '0;
      q        <= '0;
      d        <= '0;
      dvd_raw  <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      done_out <= 1'b0;
      quot_out <= '0;
      rem_out  <= '0;
      dbz_out  <= 1'b0;
    end else begin
      done_out <= 1'b0;
      case (state)
        // operand capture
        IDLE: begin
          if (start_in) begin
            q       <= magnitude(dividend_in, op_sel_in);
            d       <= magnitude(divisor_in, op_sel_in);
            dvd_raw <= dividend_in;
            sign_q  <= sd ^ sv;
            sign_r  <= sd;
            r       <= '0;
            cnt     <= CNT_TOP;
          end
        end
        // one restoring iteration per edge
        DIV: begin
          r   <= t_nonneg ? t[N_BIT:0] : r_sh[N_BIT:0];
          q   <= {q[N_BIT-2:0], t_nonneg};
          cnt <= cnt - CNT_ONE;
        end
        // sign correction and result publication
        FIX: begin
          done_out <= 1'b1;
          if (d == '0) begin
            quot_out <= '1;
            rem_out  <= dvd_raw;
            dbz_out  <= 1'b1;
          end else begin
            quot_out <= apply_sign(q, sign_q);
            rem_out  <= apply_sign(r[N_BIT-1:0], sign_r);
            dbz_out  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
